// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
//
// Contents:
//   sched_state_e - scheduler FSM states (IDLE, SHOW, SWITCH)
//   DATA_W        - width of one requester word / display word
//   SRC_IDX_W     - width of a source index (covers up to 8 sources)
//   rr_next()     - round-robin successor of a source index

package seg_sched_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned SRC_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        SWITCH
    } sched_state_e;

    // Index searched first after `idx` has been granted: (idx + 1) mod n.
    function automatic logic [SRC_IDX_W-1:0] rr_next(input logic [SRC_IDX_W-1:0] idx,
                                                     input int unsigned n);
        if (32'(idx) >= n - 1) begin
            return '0;
        end
        return idx + SRC_IDX_W'(1);
    endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker.
//
// Finds the first asserted request, searching upward from `start` and
// wrapping to 0.
//
// Ports:
//   req     in  NUM_SRC    request vector
//   start   in  SRC_IDX_W  index searched first (must be < NUM_SRC)
//   pick    out NUM_SRC    one-hot winner (all zero when no request)
//   idx     out SRC_IDX_W  index of the winner (0 when no request)
//   any_req out 1          at least one request is asserted

module seg_rr_pick
    import seg_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_IDX_W-1:0] start,
    output logic [NUM_SRC-1:0]   pick,
    output logic [SRC_IDX_W-1:0] idx,
    output logic                 any_req
);

    logic found;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        // First pass covers start..NUM_SRC-1; if nothing there, the second
        // pass returns the lowest request, which is the wrapped successor.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && (i >= int'(start)) && req[i]) begin
                found   = 1'b1;
                pick[i] = 1'b1;
                idx     = SRC_IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                pick[i] = 1'b1;
                idx     = SRC_IDX_W'(i);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/seg_display_sched.sv
// Round-robin time-sharing of the 8-digit seven-segment display.
//
// Grants the display to one of NUM_SRC requesters for 2^DWELL_BITS cycles,
// inserts a one-cycle SWITCH gap between grants, and feeds the granted word
// to the uint32_drv driver. Also produces the driver's digit-scan clock.
//
// Build option: define SEG_SCHED_HOLD_EN to snapshot the word at the grant
// edge and hold it for the whole dwell; otherwise the granted source's word
// is re-sampled on every SHOW edge (live display).
//
// Ports:
//   CLK       in  1               system clock, all state on posedge
//   RESET_N   in  1               asynchronous active-low reset
//   req       in  NUM_SRC         per-source level request
//   data_in   in  32*NUM_SRC      source i word at [32*i+31:32*i]
//   lock      in  1               freeze dwell expiry while high
//   gnt       out NUM_SRC         one-hot grant (registered)
//   src_idx   out 3               current / last granted source
//   data      out 32              word to uint32_drv .data
//   OE        out 1               to uint32_drv .OE
//   SCAN_CLK  out 1               to uint32_drv .CLK, period 2^(SCAN_DIV+1)

module seg_display_sched
    import seg_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DWELL_BITS = 25,
    parameter int unsigned SCAN_DIV   = 16
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [DATA_W*NUM_SRC-1:0]   data_in,
    input  logic                        lock,
    output logic [NUM_SRC-1:0]          gnt,
    output logic [SRC_IDX_W-1:0]        src_idx,
    output logic [DATA_W-1:0]           data,
    output logic                        OE,
    output logic                        SCAN_CLK
);

    sched_state_e          state_q;
    logic [DWELL_BITS-1:0] dwell_q;
    logic [SCAN_DIV:0]     scan_q;
    logic [SRC_IDX_W-1:0]  ptr_q;   // first index the next pick searches

    logic [NUM_SRC-1:0]    pick;
    logic [SRC_IDX_W-1:0]  pick_idx;
    logic                  pick_any;
    logic [DATA_W-1:0]     pick_word;
    logic [DATA_W-1:0]     cur_word;
    logic                  cur_req;
    logic                  dwell_done;
    logic                  do_grant;

    seg_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req     (req),
        .start   (ptr_q),
        .pick    (pick),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // Word muxes for the candidate winner and the currently shown source.
    always_comb begin
        pick_word = '0;
        cur_word  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick_idx == SRC_IDX_W'(i)) begin
                pick_word = data_in[i*DATA_W +: DATA_W];
            end
            if (src_idx == SRC_IDX_W'(i)) begin
                cur_word = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // gnt is one-hot on the shown source throughout SHOW.
    assign cur_req    = |(req & gnt);
    assign dwell_done = &dwell_q;
    // A pick only happens from IDLE or SWITCH, never preempting a dwell.
    assign do_grant   = (state_q != SHOW) && pick_any;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            gnt     <= '0;
            src_idx <= '0;
            data    <= '0;
            OE      <= 1'b0;
            dwell_q <= '0;
            ptr_q   <= '0;
        end else if (do_grant) begin
            state_q <= SHOW;
            gnt     <= pick;
            src_idx <= pick_idx;
            data    <= pick_word;
            OE      <= 1'b1;
            dwell_q <= '0;
            ptr_q   <= rr_next(pick_idx, NUM_SRC);
        end else begin
            unique case (state_q)
                IDLE: begin
                    gnt  <= '0;
                    data <= '0;
                    OE   <= 1'b0;
                end
                SHOW: begin
`ifdef SEG_SCHED_HOLD_EN
                    data <= data;
`else
                    data <= cur_word;
`endif
                    if (!lock) begin
                        dwell_q <= dwell_q + DWELL_BITS'(1);
                    end
                    // Losing the request ends the dwell even under lock.
                    if (!cur_req || (!lock && dwell_done)) begin
                        state_q <= SWITCH;
                        gnt     <= '0;
                    end
                end
                SWITCH: begin
                    // No requester left: blank the display.
                    state_q <= IDLE;
                    gnt     <= '0;
                    data    <= '0;
                    OE      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt     <= '0;
                    data    <= '0;
                    OE      <= 1'b0;
                end
            endcase
        end
    end

    // Free-running scan divider; wraps silently in every state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_q + (SCAN_DIV + 1)'(1);
        end
    end

    assign SCAN_CLK = scan_q[SCAN_DIV];

endmodule

// File: tb/tb_seg_display_sched.sv
// Self-checking bench for seg_display_sched (NUM_SRC=4, DWELL_BITS=3,
// SCAN_DIV=2). Expected grants are queued when stimulus is applied and
// checked when the DUT raises gnt.

module tb_seg_display_sched;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic [3:0]    req = '0;
    logic [127:0]  data_in = '0;
    logic          lock = 1'b0;
    logic [3:0]    gnt;
    logic [2:0]    src_idx;
    logic [31:0]   data;
    logic          OE;
    logic          SCAN_CLK;

    int n_checks = 0;
    int n_bad    = 0;
    int since_rst = 0;

    typedef struct {
        int          idx;
        logic [31:0] word;
        int          wait_n;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [31:0] W0 = 32'hA0A0_0000;
    localparam logic [31:0] W1 = 32'hB1B1_1111;
    localparam logic [31:0] W2 = 32'hC2C2_2222;
    localparam logic [31:0] W3 = 32'hD3D3_3333;

    always #5 CLK = ~CLK;

    seg_display_sched #(
        .NUM_SRC    (4),
        .DWELL_BITS (3),
        .SCAN_DIV   (2)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .req      (req),
        .data_in  (data_in),
        .lock     (lock),
        .gnt      (gnt),
        .src_idx  (src_idx),
        .data     (data),
        .OE       (OE),
        .SCAN_CLK (SCAN_CLK)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        since_rst++;
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        data_in[i*32 +: 32] = w;
    endtask

    task automatic expect_grant(input int idx, input logic [31:0] w, input int wait_n);
        exp_t e;
        e.idx    = idx;
        e.word   = w;
        e.wait_n = wait_n;
        exp_q.push_back(e);
    endtask

    // Step until gnt rises (0 -> non-zero), then compare against the queue.
    task automatic wait_grant(input int budget);
        exp_t e;
        int   n;
        bit   seen_zero;
        n         = 0;
        seen_zero = (gnt == '0);
        do begin
            tick();
            n++;
            if (gnt == '0) seen_zero = 1'b1;
        end while (!(seen_zero && gnt != '0) && n < budget);
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("grant_latency", n, e.wait_n);
        check_eq("grant_gnt", gnt, 32'(1) << e.idx);
        check_eq("grant_idx", src_idx, e.idx);
        check_eq("grant_data", data, e.word);
        check_eq("grant_oe", OE, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_gnt"}, gnt, 0);
        check_eq({tag, "_idx"}, src_idx, 0);
        check_eq({tag, "_data"}, data, 0);
        check_eq({tag, "_oe"}, OE, 0);
        check_eq({tag, "_scan"}, SCAN_CLK, 0);
    endtask

    initial begin
        // Reset and idle scan clock.
        #1 RESET_N = 1'b0;
        #2 check_reset_outputs("rst");
        #17 RESET_N = 1'b1;   // t=20, between edges
        since_rst = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_eq("idle_scan", SCAN_CLK, (since_rst >> 2) & 1);
        end
        check_eq("idle_oe", OE, 0);
        check_eq("idle_gnt", gnt, 0);
        check_eq("idle_data", data, 0);

        // Single requester: 1-edge latency, 8-cycle dwell, 1-cycle gap.
        set_word(0, 32'hDEADBEEF);
        req = 4'b0001;
        expect_grant(0, 32'hDEADBEEF, 1);
        wait_grant(4);
        for (int k = 0; k < 7; k++) tick();
        check_eq("dwell_end_gnt", gnt, 4'b0001);
        tick();
        check_eq("switch_gnt", gnt, 0);
        check_eq("switch_oe", OE, 1);
        check_eq("switch_data", data, 32'hDEADBEEF);
        expect_grant(0, 32'hDEADBEEF, 1);
        wait_grant(4);

        // Round robin over sources 0, 1, 3 with 9-cycle spacing.
        set_word(0, W0);
        set_word(1, W1);
        set_word(2, W2);
        set_word(3, W3);
        req = 4'b1011;
        expect_grant(1, W1, 9);
        expect_grant(3, W3, 9);
        expect_grant(0, W0, 9);
        for (int k = 0; k < 3; k++) wait_grant(20);

        // Request drop mid-dwell ends the dwell early.
        expect_grant(1, W1, 9);
        wait_grant(20);
        tick();
        tick();
        req = 4'b1001;
        tick();
        check_eq("drop_gnt", gnt, 0);
        check_eq("drop_oe", OE, 1);
        check_eq("drop_data", data, W1);
        check_eq("drop_idx", src_idx, 1);
        expect_grant(3, W3, 1);
        wait_grant(4);
        req = 4'b0000;
        tick();
        check_eq("nreq_switch_gnt", gnt, 0);
        check_eq("nreq_switch_oe", OE, 1);
        tick();
        check_eq("nreq_idle_oe", OE, 0);
        check_eq("nreq_idle_data", data, 0);
        check_eq("nreq_idle_idx", src_idx, 3);

        // Lock freezes the dwell; release resumes a full dwell.
        req = 4'b0001;
        expect_grant(0, W0, 1);
        wait_grant(4);
        lock = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("lock_hold", gnt, 4'b0001);
        end
        lock = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check_eq("unlock_last", gnt, 4'b0001);
        tick();
        check_eq("unlock_switch", gnt, 0);
        expect_grant(0, W0, 1);
        wait_grant(4);

        // Mid-dwell data change.
        tick();
        tick();
        set_word(0, 32'h12345678);
        tick();
`ifdef SEG_SCHED_HOLD_EN
        check_eq("mid_data", data, W0);
`else
        check_eq("mid_data", data, 32'h12345678);
`endif
        expect_grant(0, 32'h12345678, 6);
        wait_grant(20);

        // Asynchronous reset mid-SHOW; the round-robin pointer restarts at 0.
        tick();
        tick();
        tick();
        #2 RESET_N = 1'b0;
        #1 check_reset_outputs("async_rst");
        req = 4'b1011;
        #1 RESET_N = 1'b1;
        since_rst = 0;
        expect_grant(0, 32'h12345678, 1);
        wait_grant(4);
        for (int k = 0; k < 3; k++) tick();
        check_eq("post_rst_scan_hi", SCAN_CLK, 1);
        for (int k = 0; k < 4; k++) tick();
        check_eq("post_rst_scan_lo", SCAN_CLK, 0);

        check_eq("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
